// File: rtl/iter_muldiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// master: issuing EX stage; slave: the unit itself.
interface iter_muldiv_if #(
    parameter int XLEN = 64
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic            in_word;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic            busy;

    modport master (
        output in_valid, in_op, in_word, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, busy
    );

    modport slave (
        input  in_valid, in_op, in_word, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, busy
    );
endinterface

// File: rtl/iter_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// magnitude arithmetic with sign fix-up on DONE entry, valid/ready on both sides.
module iter_muldiv_unit #(
    parameter int XLEN           = 64,
    parameter int HAS_WORD       = 1,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    iter_muldiv_if.slave bus
);
    localparam int PW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t          state_r;
    logic [7:0]      cnt_r;
    logic [2:0]      op_r;
    logic            word_r;
    logic            neg_r;
    logic [PW-1:0]   acc_r;
    logic [PW-1:0]   mc_r;
    logic [XLEN-1:0] mp_r;
    logic [XLEN-1:0] out_res_r;
    logic            out_valid_r;
    logic            in_ready_r;
    logic            busy_r;

    // Extend a 32-bit quantity in the low bits to XLEN, signed or unsigned.
    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) begin
            r[i] = sgn & v[31];
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] sext_res(input logic [XLEN-1:0] v, input logic word);
        return word ? ext32(v, 1'b1) : v;
    endfunction

    logic            word_s, a_sgn_s, b_sgn_s, is_div_s, is_rem_s;
    logic            sa_s, sb_s, b_zero_s, ovf_s, special_s;
    logic [XLEN-1:0] a_ext_s, b_ext_s, mag_a_s, mag_b_s, min_s, spec_res_s;

    // Request decode: operand extension, magnitudes and division special cases.
    always_comb begin
        word_s   = (HAS_WORD != 0) && bus.in_word;
        is_div_s = bus.in_op[2];
        is_rem_s = bus.in_op[2] & bus.in_op[1];
        a_sgn_s  = (bus.in_op == 3'd1) || (bus.in_op == 3'd2) ||
                   (bus.in_op == 3'd4) || (bus.in_op == 3'd6);
        b_sgn_s  = (bus.in_op == 3'd1) || (bus.in_op == 3'd4) || (bus.in_op == 3'd6);
        a_ext_s  = word_s ? ext32(bus.in_a, a_sgn_s) : bus.in_a;
        b_ext_s  = word_s ? ext32(bus.in_b, b_sgn_s) : bus.in_b;
        sa_s     = a_sgn_s & a_ext_s[XLEN-1];
        sb_s     = b_sgn_s & b_ext_s[XLEN-1];
        mag_a_s  = sa_s ? ({XLEN{1'b0}} - a_ext_s) : a_ext_s;
        mag_b_s  = sb_s ? ({XLEN{1'b0}} - b_ext_s) : b_ext_s;
        min_s    = word_s ? ~XLEN'(32'h7FFF_FFFF) : {1'b1, {(XLEN-1){1'b0}}};
        b_zero_s = (b_ext_s == {XLEN{1'b0}});
        ovf_s    = is_div_s & a_sgn_s & (a_ext_s == min_s) & (&b_ext_s);
        special_s = is_div_s & (b_zero_s | ovf_s);
        if (b_zero_s) begin
            spec_res_s = is_rem_s ? sext_res(a_ext_s, word_s) : {XLEN{1'b1}};
        end else begin
            spec_res_s = is_rem_s ? {XLEN{1'b0}} : sext_res(a_ext_s, word_s);
        end
    end

    logic [PW-1:0]   acc_n_s, mc_n_s, prod_s;
    logic [XLEN-1:0] mp_n_s, quo_s, fin_s;
    logic [XLEN:0]   rem_s;
    logic [7:0]      steps_s;

    // One CALC cycle: BITS_PER_CYCLE shift-add or restoring-divide steps, then final fix-up.
    always_comb begin
        acc_n_s = acc_r;
        mc_n_s  = mc_r;
        mp_n_s  = mp_r;
        rem_s   = {(XLEN+1){1'b0}};
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (op_r[2]) begin
                rem_s  = {acc_n_s[XLEN-1:0], mp_n_s[XLEN-1]};
                mp_n_s = {mp_n_s[XLEN-2:0], 1'b0};
                if (rem_s >= {1'b0, mc_n_s[XLEN-1:0]}) begin
                    rem_s     = rem_s - {1'b0, mc_n_s[XLEN-1:0]};
                    mp_n_s[0] = 1'b1;
                end else begin
                    mp_n_s[0] = 1'b0;
                end
                acc_n_s = {{XLEN{1'b0}}, rem_s[XLEN-1:0]};
            end else begin
                if (mp_n_s[0]) begin
                    acc_n_s = acc_n_s + mc_n_s;
                end else begin
                    acc_n_s = acc_n_s;
                end
                mc_n_s = {mc_n_s[PW-2:0], 1'b0};
                mp_n_s = {1'b0, mp_n_s[XLEN-1:1]};
            end
        end
        steps_s = word_r ? 8'(32 / BITS_PER_CYCLE) : 8'(XLEN / BITS_PER_CYCLE);
        prod_s  = neg_r ? ({PW{1'b0}} - acc_n_s) : acc_n_s;
        quo_s   = op_r[1] ? acc_n_s[XLEN-1:0] : mp_n_s;
        quo_s   = neg_r ? ({XLEN{1'b0}} - quo_s) : quo_s;
        if (op_r[2]) begin
            fin_s = sext_res(quo_s, word_r);
        end else if (op_r == 3'd0) begin
            fin_s = sext_res(prod_s[XLEN-1:0], word_r);
        end else if (word_r) begin
            fin_s = sext_res(prod_s[XLEN+31:32], 1'b1);
        end else begin
            fin_s = prod_s[PW-1:XLEN];
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            op_r        <= 3'd0;
            word_r      <= 1'b0;
            neg_r       <= 1'b0;
            acc_r       <= {PW{1'b0}};
            mc_r        <= {PW{1'b0}};
            mp_r        <= {XLEN{1'b0}};
            out_res_r   <= {XLEN{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else if (flush) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_r       <= bus.in_op;
                        word_r     <= word_s;
                        neg_r      <= is_rem_s ? sa_s : (sa_s ^ sb_s);
                        cnt_r      <= 8'd0;
                        acc_r      <= {PW{1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (is_div_s) begin
                            // Dividend is left-aligned so quotient bits always come from the MSB.
                            mc_r <= {{XLEN{1'b0}}, mag_b_s};
                            mp_r <= word_s ? (mag_a_s << 32) : mag_a_s;
                        end else begin
                            mc_r <= {{XLEN{1'b0}}, mag_a_s};
                            mp_r <= mag_b_s;
                        end
                        if (special_s) begin
                            state_r     <= DONE;
                            out_res_r   <= spec_res_s;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    acc_r <= acc_n_s;
                    mc_r  <= mc_n_s;
                    mp_r  <= mp_n_s;
                    cnt_r <= cnt_r + 8'd1;
                    if ((cnt_r + 8'd1) == steps_s) begin
                        state_r     <= DONE;
                        out_res_r   <= fin_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r <= CALC;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_res   = out_res_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed and model-checked bench for iter_muldiv_unit (BPC=1 and BPC=2 instances).
module tb_iter_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    iter_muldiv_if #(.XLEN(64)) b1 ();
    iter_muldiv_if #(.XLEN(64)) b2 ();

    iter_muldiv_unit #(.XLEN(64), .HAS_WORD(1), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b1.slave));
    iter_muldiv_unit #(.XLEN(64), .HAS_WORD(1), .BITS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b2.slave));

    // Independent RISC-V M reference built on native wide arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] op, input bit word,
                                              input logic [63:0] a, input logic [63:0] b);
        logic        a_s, b_s;
        logic [31:0] a32, b32, q32, r32, res32;
        logic [63:0] pa64, pb64, p64, q64, r64, res;
        logic [127:0] pa, pb, p;
        a_s = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_s = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a32 = a[31:0];
        b32 = b[31:0];
        if (word) begin
            if (!op[2]) begin
                pa64  = a_s ? {{32{a32[31]}}, a32} : {32'h0, a32};
                pb64  = b_s ? {{32{b32[31]}}, b32} : {32'h0, b32};
                p64   = pa64 * pb64;
                res32 = (op == 3'd0) ? p64[31:0] : p64[63:32];
            end else begin
                if (b32 == 32'h0) begin
                    q32 = 32'hFFFF_FFFF; r32 = a32;
                end else if (a_s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                    q32 = a32; r32 = 32'h0;
                end else if (a_s) begin
                    q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
                end else begin
                    q32 = a32 / b32; r32 = a32 % b32;
                end
                res32 = op[1] ? r32 : q32;
            end
            res = {{32{res32[31]}}, res32};
        end else begin
            if (!op[2]) begin
                pa  = a_s ? {{64{a[63]}}, a} : {64'h0, a};
                pb  = b_s ? {{64{b[63]}}, b} : {64'h0, b};
                p   = pa * pb;
                res = (op == 3'd0) ? p[63:0] : p[127:64];
            end else begin
                if (b == 64'h0) begin
                    q64 = 64'hFFFF_FFFF_FFFF_FFFF; r64 = a;
                end else if (a_s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                    q64 = a; r64 = 64'h0;
                end else if (a_s) begin
                    q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b);
                end else begin
                    q64 = a / b; r64 = a % b;
                end
                res = op[1] ? r64 : q64;
            end
        end
        return res;
    endfunction

    task automatic drive_op(input bit sel, input logic [2:0] op, input bit word,
                            input logic [63:0] a, input logic [63:0] b);
        if (sel) begin
            b2.in_valid = 1'b1; b2.in_op = op; b2.in_word = word; b2.in_a = a; b2.in_b = b;
        end else begin
            b1.in_valid = 1'b1; b1.in_op = op; b1.in_word = word; b1.in_a = a; b1.in_b = b;
        end
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        b2.in_valid = 1'b0;
    endtask

    // Latency counts cycles after the accept cycle; -1 marks a timeout.
    task automatic wait_result(input bit sel, output logic [63:0] res, output int lat);
        logic v;
        res = 64'hx;
        lat = -1;
        for (int c = 1; c < 200; c++) begin
            v = sel ? b2.out_valid : b1.out_valid;
            if (v) begin
                lat = c;
                res = sel ? b2.out_res : b1.out_res;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic consume(input bit sel);
        if (sel) b2.out_ready = 1'b1; else b1.out_ready = 1'b1;
        @(posedge clk); #1;
        b1.out_ready = 1'b0;
        b2.out_ready = 1'b0;
    endtask

    task automatic run_check(input string name, input bit sel, input logic [2:0] op, input bit word,
                             input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] exp_res, input int exp_lat);
        logic [63:0] res;
        int          lat;
        drive_op(sel, op, word, a, b);
        wait_result(sel, res, lat);
        checks++;
        if (res !== exp_res) $display("FAIL %s result: got %h want %h", name, res, exp_res);
        else passed++;
        checks++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        else passed++;
        consume(sel);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (b1.in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", b1.in_ready); else passed++;
        checks++; if (b1.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", b1.out_valid); else passed++;
        checks++; if (b1.busy !== 1'b0) $display("FAIL reset busy: got %b want 0", b1.busy); else passed++;
        checks++; if (b1.out_res !== 64'h0) $display("FAIL reset out_res: got %h want 0", b1.out_res); else passed++;
        checks++; if (b2.in_ready !== 1'b1) $display("FAIL reset2 in_ready: got %b want 1", b2.in_ready); else passed++;
    endtask

    task automatic test_mul();
        run_check("mul_7x-3", 1'b0, 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        run_check("mulhu_max", 1'b0, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_check("mulw_sext", 1'b0, 3'd0, 1'b1, 64'h0000_0000_4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 33);
    endtask

    task automatic test_div_special();
        run_check("divw_ovf", 1'b0, 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_8000_0000, 1);
        run_check("remw_ovf", 1'b0, 3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1);
        run_check("divu_by0", 1'b0, 3'd5, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_check("remu_by0", 1'b0, 3'd7, 1'b0, 64'd123, 64'd0, 64'd123, 1);
    endtask

    task automatic test_div_signed();
        run_check("rem_-7_2", 1'b0, 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_check("div_-7_2", 1'b0, 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    endtask

    task automatic test_backpressure();
        logic [63:0] res;
        int          lat;
        drive_op(1'b0, 3'd5, 1'b0, 64'd100, 64'd7);
        wait_result(1'b0, res, lat);
        checks++; if (lat !== 65) $display("FAIL bp latency: got %0d want 65", lat); else passed++;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (b1.out_res !== 64'd14 || b1.out_valid !== 1'b1 || b1.in_ready !== 1'b0)
                $display("FAIL bp hold %0d: res %h valid %b ready %b want 14/1/0",
                         i, b1.out_res, b1.out_valid, b1.in_ready);
            else passed++;
            @(posedge clk); #1;
        end
        consume(1'b0);
        checks++;
        if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || b1.busy !== 1'b0)
            $display("FAIL bp release: ready %b valid %b busy %b want 1/0/0", b1.in_ready, b1.out_valid, b1.busy);
        else passed++;
    endtask

    task automatic test_flush();
        bit seen;
        drive_op(1'b0, 3'd0, 1'b0, 64'd5, 64'd9);
        repeat (19) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (b1.busy !== 1'b0 || b1.in_ready !== 1'b1)
            $display("FAIL flush idle: busy %b ready %b want 0/1", b1.busy, b1.in_ready);
        else passed++;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (b1.out_valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL flush no_valid: got %b want 0", seen); else passed++;
        run_check("after_flush_div", 1'b0, 3'd4, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        // Flush in the accept cycle must cancel the accept.
        b1.in_valid = 1'b1; b1.in_op = 3'd0; b1.in_word = 1'b0; b1.in_a = 64'd3; b1.in_b = 64'd3;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; b1.in_valid = 1'b0;
        checks++;
        if (b1.busy !== 1'b0 || b1.in_ready !== 1'b1)
            $display("FAIL flush_accept: busy %b ready %b want 0/1", b1.busy, b1.in_ready);
        else passed++;
    endtask

    task automatic test_rst_mid();
        drive_op(1'b0, 3'd4, 1'b0, 64'd1000, 64'd3);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (b1.busy !== 1'b0 || b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || b1.out_res !== 64'h0)
            $display("FAIL rst_mid: busy %b ready %b valid %b res %h want 0/1/0/0",
                     b1.busy, b1.in_ready, b1.out_valid, b1.out_res);
        else passed++;
    endtask

    task automatic test_bpc2_random();
        logic [2:0]  op;
        bit          word, bz, ov;
        logic [63:0] a, b, exp_res, res;
        int          lat, exp_lat;
        for (int i = 0; i < 24; i++) begin
            op   = 3'($urandom_range(0, 7));
            word = 1'($urandom_range(0, 1));
            if (word && op >= 3'd1 && op <= 3'd3) op = 3'd0;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case (i % 4)
                0: b = 64'h0;
                1: begin
                    a = word ? 64'h1234_5678_8000_0000 : 64'h8000_0000_0000_0000;
                    b = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                2: b = ($urandom_range(0, 1) != 0) ? 64'(-$urandom_range(1, 20)) : 64'($urandom_range(1, 20));
                default: ;
            endcase
            exp_res = ref_model(op, word, a, b);
            bz = word ? (b[31:0] == 32'h0) : (b == 64'h0);
            ov = (op == 3'd4 || op == 3'd6) &&
                 (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
            exp_lat = (op[2] && (bz || ov)) ? 1 : (word ? 17 : 33);
            drive_op(1'b1, op, word, a, b);
            wait_result(1'b1, res, lat);
            checks++;
            if (res !== exp_res)
                $display("FAIL bpc2 op%0d w%0d a=%h b=%h: got %h want %h", op, word, a, b, res, exp_res);
            else passed++;
            checks++;
            if (lat !== exp_lat) $display("FAIL bpc2 latency op%0d w%0d: got %0d want %0d", op, word, lat, exp_lat);
            else passed++;
            consume(1'b1);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        b1.in_valid = 1'b0; b1.in_op = 3'd0; b1.in_word = 1'b0; b1.in_a = 64'h0; b1.in_b = 64'h0; b1.out_ready = 1'b0;
        b2.in_valid = 1'b0; b2.in_op = 3'd0; b2.in_word = 1'b0; b2.in_a = 64'h0; b2.in_b = 64'h0; b2.out_ready = 1'b0;
        test_reset();
        test_mul();
        test_div_special();
        test_div_signed();
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_bpc2_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
